usb_cdc_echo_fifo: RTL and testbench
====================================

Name: usb_cdc_echo_fifo

Overview:
- Byte-stream stage attached directly to the usb_cdc_core data ports.
- Consumes the core's OUT-endpoint byte stream (outport_*), buffers it in a FIFO, and feeds it back to the core's IN-endpoint port (inport_*).
- Turns the simulation USB device into an echo/loopback target, so host-side USB traffic can be checked end to end.
- Optionally case-converts bytes and expands CR to CR LF on the way back.

Parameters:
- DEPTH, 16, FIFO entries; power of two, minimum 4.
- UPPERCASE, 0, 1 = bytes 0x61..0x7A are presented as value minus 0x20 on inport_data_o; FIFO stores bytes unmodified.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous active-high reset
- enable_i  in  1  0 = freeze both handshakes; FIFO contents held
- outport_valid_i  in  1  byte valid from usb_cdc_core
- outport_data_i  in  8  received byte
- outport_accept_o  out  1  this block accepts the byte
- inport_valid_o  out  1  byte valid toward usb_cdc_core
- inport_data_o  out  8  byte to transmit
- inport_accept_i  in  1  usb_cdc_core accepts the byte
- level_o  out  $clog2(DEPTH)+1  current FIFO occupancy
- rx_count_o  out  16  bytes pushed; wraps 0xFFFF->0
- tx_count_o  out  16  bytes delivered, including inserted LF; wraps

Behaviour:
- Reset: clk_i and rst_i are the only clock and reset; reset is synchronous, active-high.
- After reset: wr_ptr = rd_ptr = 0, level_o = 0, both counters 0, state S_DATA.
- Reset values of outputs: inport_valid_o = 0, inport_data_o = 0x00. outport_accept_o = enable_i, since the FIFO is empty.
- Push: outport_accept_o = enable_i && (level < DEPTH), decoded from registered state only.
  - No combinational path from inport_accept_i to outport_accept_o.
  - Push occurs when outport_valid_i && outport_accept_o.
- Pop, S_DATA: inport_valid_o = enable_i && (level != 0). inport_data_o = mem[rd_ptr], show-ahead, UPPERCASE transform applied.
  - Pop occurs when inport_valid_o && inport_accept_i.
- Latency: a byte pushed into an empty FIFO appears on inport_valid_o the next cycle. There is no same-cycle bypass.
- Simultaneous push and pop: level is unchanged and both counters increment.
  - When full, a pop does not enable a same-cycle push; accept rises the following cycle.
- Pointer wrap: pointers are $clog2(DEPTH) bits and wrap naturally. level_o is tracked separately so full and empty are unambiguous.
- level_o, rx_count_o and tx_count_o update one cycle after the handshake; they are registered.
- enable_i = 0: both valid/accept outputs are forced low the same cycle.
  - No push or pop occurs; state, counters and data are held.
  - Operation resumes on the first cycle enable_i = 1.
- Reset asserted mid-stream: all buffered bytes are discarded and any pending LF is lost. The next cycle matches the reset state.

Optional Feature:
- Macro: USB_CDC_ECHO_CRLF_EN.
- Defined: a two-state FSM, S_DATA / S_LF.
  - In S_DATA, popping byte 0x0D moves to S_LF.
  - In S_LF: inport_valid_o = enable_i, inport_data_o = 0x0A, the FIFO is not popped, and UPPERCASE does not apply.
  - On inport_accept_i in S_LF: tx_count increments and the state returns to S_DATA.
  - Pushes continue normally during S_LF.
  - Reset forces S_DATA.
- Not defined: no FSM logic; bytes pass 1:1 and 0x0D is sent unmodified.

Test Plan:
1. Reset with enable_i = 1, rst_i held 3 cycles -> level_o = 0, inport_valid_o = 0, outport_accept_o = 1, counters 0.
2. UPPERCASE = 1, push 0x61, 0x42, 0x7A with inport_accept_i = 0 -> level_o = 3. Then inport_accept_i = 1 -> outputs 0x41, 0x42, 0x5A on consecutive cycles; rx_count_o = tx_count_o = 3.
3. DEPTH = 16, hold outport_valid_i = 1 with no pops -> 16 bytes accepted, then outport_accept_o = 0, level_o = 16. Single pop -> accept = 1 on the next cycle and the 17th byte is pushed.
4. Preload 5 bytes, then push and pop every cycle for 10 cycles -> level_o stays 5, output order equals input order, rx_count_o = 15, tx_count_o = 10.
5. Level 4, drop enable_i for 6 cycles with valid/accept held high -> inport_valid_o = 0, outport_accept_o = 0, level_o = 4. Re-enable -> drain resumes with the first byte unchanged.
6. Push 0x0D, 0x41:
   - With USB_CDC_ECHO_CRLF_EN -> output 0x0D, 0x0A, 0x41 and tx_count_o = 3.
   - Without -> output 0x0D, 0x41 and tx_count_o = 2.
   - With the macro, reset asserted while in S_LF -> no 0x0A emitted afterwards.

Source files
------------

// File: rtl/usb_cdc_echo_fifo.sv
// -----------------------------------------------------------------------------
// usb_cdc_echo_fifo
//
// Loopback stage for the usb_cdc_core byte ports. Bytes received from the
// core's OUT endpoint (outport_*) are buffered in a FIFO and handed back to the
// core's IN endpoint (inport_*). This turns a simulated USB CDC device into an
// echo target for end-to-end host traffic checks.
//
// Optional build macro: USB_CDC_ECHO_CRLF_EN
//   When defined, every popped 0x0D is followed by an inserted 0x0A (CR -> CR LF).
//   When undefined, bytes pass through 1:1.
//
// Parameters:
//   DEPTH      FIFO entries (power of two, >= 4)
//   UPPERCASE  1 = bytes 0x61..0x7A leave as value - 0x20 (FIFO keeps raw bytes)
//
// Ports:
//   clk_i, rst_i       clock, synchronous active-high reset
//   enable_i           0 = both handshakes forced low, everything held
//   outport_valid_i    byte valid from the core (OUT endpoint data)
//   outport_data_i     received byte
//   outport_accept_o   this block takes the byte
//   inport_valid_o     byte valid toward the core (IN endpoint data)
//   inport_data_o      byte to transmit
//   inport_accept_i    core takes the byte
//   level_o            FIFO occupancy (registered)
//   rx_count_o         bytes pushed, wraps at 16 bits
//   tx_count_o         bytes delivered including inserted LF, wraps at 16 bits
// -----------------------------------------------------------------------------
module usb_cdc_echo_fifo #(
   parameter int DEPTH     = 16,
   parameter int UPPERCASE = 0
) (
   input  logic                     clk_i,
   input  logic                     rst_i,
   input  logic                     enable_i,
   input  logic                     outport_valid_i,
   input  logic [7:0]               outport_data_i,
   output logic                     outport_accept_o,
   output logic                     inport_valid_o,
   output logic [7:0]               inport_data_o,
   input  logic                     inport_accept_i,
   output logic [$clog2(DEPTH):0]   level_o,
   output logic [15:0]              rx_count_o,
   output logic [15:0]              tx_count_o
);

   localparam int AW = $clog2(DEPTH);
   localparam int LW = AW + 1;
   localparam logic [LW-1:0] FULL_LEVEL = LW'(DEPTH);

   // Storage array; write-only from the push side, read show-ahead at rd_ptr.
   logic [7:0]    mem [DEPTH];

   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [LW-1:0] level_q, level_d;
   logic [15:0]   rx_count_q, rx_count_d;
   logic [15:0]   tx_count_q, tx_count_d;

   logic          push;
   logic          pop;
   logic          lf_sent;
   logic          fifo_empty;
   logic [7:0]    head_raw;
   logic [7:0]    head_out;

   assign fifo_empty = (level_q == '0);

   // Accept depends only on registered occupancy, so a pop while full cannot
   // open the push side in the same cycle.
   assign outport_accept_o = enable_i && (level_q != FULL_LEVEL);
   assign push             = outport_valid_i && outport_accept_o;

   // Gate the head byte so an empty FIFO presents 0x00 rather than stale RAM.
   assign head_raw = fifo_empty ? 8'h00 : mem[rd_ptr_q];

   generate
      if (UPPERCASE != 0) begin : g_upper
         always_comb begin
            head_out = head_raw;
            if ((head_raw >= 8'h61) && (head_raw <= 8'h7A)) begin
               head_out = head_raw - 8'h20;
            end
         end
      end else begin : g_pass
         assign head_out = head_raw;
      end
   endgenerate

`ifdef USB_CDC_ECHO_CRLF_EN
   typedef enum logic {S_DATA = 1'b0, S_LF = 1'b1} state_t;

   state_t state_q, state_d;
   logic   data_valid;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= S_DATA;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d        = state_q;
      inport_valid_o = 1'b0;
      inport_data_o  = 8'h00;
      pop            = 1'b0;
      lf_sent        = 1'b0;
      data_valid     = enable_i && !fifo_empty;
      case (state_q)
         S_DATA: begin
            inport_valid_o = data_valid;
            inport_data_o  = head_out;
            pop            = data_valid && inport_accept_i;
            // Compare the raw byte: case conversion never touches 0x0D.
            if (pop && (head_raw == 8'h0D)) begin
               state_d = S_LF;
            end
         end
         S_LF: begin
            // Inserted LF is emitted without consuming a FIFO entry.
            inport_valid_o = enable_i;
            inport_data_o  = 8'h0A;
            if (enable_i && inport_accept_i) begin
               lf_sent = 1'b1;
               state_d = S_DATA;
            end
         end
         default: begin
            state_d = S_DATA;
         end
      endcase
   end
`else
   always_comb begin
      inport_valid_o = enable_i && !fifo_empty;
      inport_data_o  = head_out;
      pop            = enable_i && !fifo_empty && inport_accept_i;
      lf_sent        = 1'b0;
   end
`endif

   always_comb begin
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      level_d    = level_q;
      rx_count_d = rx_count_q;
      tx_count_d = tx_count_q;

      if (push) begin
         wr_ptr_d   = wr_ptr_q + 1'b1;
         rx_count_d = rx_count_q + 16'd1;
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + 1'b1;
      end
      if (pop || lf_sent) begin
         tx_count_d = tx_count_q + 16'd1;
      end

      case ({push, pop})
         2'b10:   level_d = level_q + 1'b1;
         2'b01:   level_d = level_q - 1'b1;
         default: level_d = level_q;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         level_q    <= '0;
         rx_count_q <= '0;
         tx_count_q <= '0;
      end else begin
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         level_q    <= level_d;
         rx_count_q <= rx_count_d;
         tx_count_q <= tx_count_d;
      end
   end

   // RAM write port has no reset; contents are only visible when level != 0.
   always_ff @(posedge clk_i) begin
      if (push) begin
         mem[wr_ptr_q] <= outport_data_i;
      end
   end

   assign level_o    = level_q;
   assign rx_count_o = rx_count_q;
   assign tx_count_o = tx_count_q;

endmodule

// File: tb/tb_usb_cdc_echo_fifo.sv
// -----------------------------------------------------------------------------
// tb_usb_cdc_echo_fifo
//
// Directed bench for usb_cdc_echo_fifo (DEPTH = 16, UPPERCASE = 1). Stimulus
// pushes the expected IN-side bytes into a queue; an independent monitor pops
// and compares on every IN handshake. Registered status outputs are checked
// directly against hand-computed values.
// -----------------------------------------------------------------------------
module tb_usb_cdc_echo_fifo;

   logic        clk_i;
   logic        rst_i;
   logic        enable_i;
   logic        outport_valid_i;
   logic [7:0]  outport_data_i;
   logic        outport_accept_o;
   logic        inport_valid_o;
   logic [7:0]  inport_data_o;
   logic        inport_accept_i;
   logic [4:0]  level_o;
   logic [15:0] rx_count_o;
   logic [15:0] tx_count_o;

   int tests_run = 0;
   int fail_cnt  = 0;

   logic [7:0] exp_q[$];

`ifdef USB_CDC_ECHO_CRLF_EN
   localparam bit CRLF = 1'b1;
`else
   localparam bit CRLF = 1'b0;
`endif

   usb_cdc_echo_fifo #(
      .DEPTH     (16),
      .UPPERCASE (1)
   ) dut (
      .clk_i            (clk_i),
      .rst_i            (rst_i),
      .enable_i         (enable_i),
      .outport_valid_i  (outport_valid_i),
      .outport_data_i   (outport_data_i),
      .outport_accept_o (outport_accept_o),
      .inport_valid_o   (inport_valid_o),
      .inport_data_o    (inport_data_o),
      .inport_accept_i  (inport_accept_i),
      .level_o          (level_o),
      .rx_count_o       (rx_count_o),
      .tx_count_o       (tx_count_o)
   );

   initial clk_i = 1'b0;
   always #5 clk_i = ~clk_i;

   // Monitor: one line per delivered byte, compared against the scoreboard.
   always @(negedge clk_i) begin
      if (!rst_i && inport_valid_o && inport_accept_i) begin
         tests_run++;
         if (exp_q.size() == 0) begin
            fail_cnt++;
            $display("FAIL tx_unexpected: got %02h, required no byte", inport_data_o);
         end else begin
            logic [7:0] e;
            e = exp_q.pop_front();
            if (inport_data_o !== e) begin
               fail_cnt++;
               $display("FAIL tx_data: got %02h, required %02h", inport_data_o, e);
            end else begin
               $display("[TB] tx byte %02h ok", inport_data_o);
            end
         end
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      tests_run++;
      if (act !== req) begin
         fail_cnt++;
         $display("FAIL %s: got %0h, required %0h", name, act, req);
      end
   endtask

   task automatic step();
      @(posedge clk_i);
      #1;
   endtask

   task automatic do_reset();
      outport_valid_i = 1'b0;
      inport_accept_i = 1'b0;
      enable_i        = 1'b1;
      rst_i           = 1'b1;
      exp_q.delete();
      step();
      rst_i = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, required completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst_i           = 1'b1;
      enable_i        = 1'b1;
      outport_valid_i = 1'b0;
      outport_data_i  = 8'h00;
      inport_accept_i = 1'b0;

      // 1: reset held 3 cycles
      repeat (3) @(posedge clk_i);
      #1 rst_i = 1'b0;
      #1;
      chk("rst_level",  32'(level_o), 0);
      chk("rst_ivalid", 32'(inport_valid_o), 0);
      chk("rst_idata",  32'(inport_data_o), 0);
      chk("rst_oaccept", 32'(outport_accept_o), 1);
      chk("rst_rx", 32'(rx_count_o), 0);
      chk("rst_tx", 32'(tx_count_o), 0);

      // 2: uppercase conversion
      exp_q.push_back(8'h41);
      exp_q.push_back(8'h42);
      exp_q.push_back(8'h5A);
      outport_valid_i = 1'b1;
      outport_data_i  = 8'h61;
      #1;
      chk("no_bypass_valid", 32'(inport_valid_o), 0);
      step();
      #1;
      chk("latency_valid", 32'(inport_valid_o), 1);
      chk("latency_data",  32'(inport_data_o), 32'h41);
      outport_data_i = 8'h42;
      step();
      outport_data_i = 8'h7A;
      step();
      outport_valid_i = 1'b0;
      #1;
      chk("uc_level", 32'(level_o), 3);
      chk("uc_rx",    32'(rx_count_o), 3);
      inport_accept_i = 1'b1;
      repeat (3) step();
      inport_accept_i = 1'b0;
      #1;
      chk("uc_tx",     32'(tx_count_o), 3);
      chk("uc_empty",  32'(level_o), 0);
      chk("uc_ivalid", 32'(inport_valid_o), 0);

      // 3: fill to DEPTH, full back-pressure, single pop
      for (int i = 0; i < 16; i++) exp_q.push_back(8'(8'h80 + i));
      exp_q.push_back(8'h90);
      outport_valid_i = 1'b1;
      for (int i = 0; i < 16; i++) begin
         outport_data_i = 8'(8'h80 + i);
         step();
      end
      outport_data_i = 8'h90;
      repeat (2) step();
      #1;
      chk("full_accept", 32'(outport_accept_o), 0);
      chk("full_level",  32'(level_o), 16);
      chk("full_rx",     32'(rx_count_o), 19);
      inport_accept_i = 1'b1;
      #1;
      chk("full_pop_accept", 32'(outport_accept_o), 0);
      step();
      inport_accept_i = 1'b0;
      #1;
      chk("after_pop_accept", 32'(outport_accept_o), 1);
      chk("after_pop_level",  32'(level_o), 15);
      step();
      outport_valid_i = 1'b0;
      #1;
      chk("refill_level", 32'(level_o), 16);
      chk("refill_rx",    32'(rx_count_o), 20);
      inport_accept_i = 1'b1;
      repeat (16) step();
      inport_accept_i = 1'b0;
      #1;
      chk("drain_level", 32'(level_o), 0);
      chk("drain_tx",    32'(tx_count_o), 20);

      // 4: preload 5, then push+pop every cycle
      do_reset();
      for (int i = 0; i < 15; i++) exp_q.push_back(8'(8'h10 + i));
      outport_valid_i = 1'b1;
      for (int i = 0; i < 5; i++) begin
         outport_data_i = 8'(8'h10 + i);
         step();
      end
      inport_accept_i = 1'b1;
      for (int i = 0; i < 10; i++) begin
         outport_data_i = 8'(8'h15 + i);
         step();
         chk("stream_level", 32'(level_o), 5);
      end
      outport_valid_i = 1'b0;
      inport_accept_i = 1'b0;
      #1;
      chk("stream_rx", 32'(rx_count_o), 15);
      chk("stream_tx", 32'(tx_count_o), 10);
      inport_accept_i = 1'b1;
      repeat (5) step();
      inport_accept_i = 1'b0;

      // 5: enable low freezes everything
      for (int i = 0; i < 4; i++) exp_q.push_back(8'(8'h20 + i));
      outport_valid_i = 1'b1;
      for (int i = 0; i < 4; i++) begin
         outport_data_i = 8'(8'h20 + i);
         step();
      end
      outport_data_i  = 8'h24;
      enable_i        = 1'b0;
      inport_accept_i = 1'b1;
      #1;
      chk("dis_ivalid",  32'(inport_valid_o), 0);
      chk("dis_oaccept", 32'(outport_accept_o), 0);
      repeat (6) step();
      chk("dis_level", 32'(level_o), 4);
      chk("dis_rx",    32'(rx_count_o), 19);
      chk("dis_tx",    32'(tx_count_o), 15);
      outport_valid_i = 1'b0;
      enable_i        = 1'b1;
      repeat (4) step();
      inport_accept_i = 1'b0;
      #1;
      chk("reen_level", 32'(level_o), 0);
      chk("reen_tx",    32'(tx_count_o), 19);

      // 6: CR handling
      do_reset();
      exp_q.push_back(8'h0D);
      if (CRLF) exp_q.push_back(8'h0A);
      exp_q.push_back(8'h41);
      outport_valid_i = 1'b1;
      outport_data_i  = 8'h0D;
      step();
      outport_data_i  = 8'h41;
      step();
      outport_valid_i = 1'b0;
      inport_accept_i = 1'b1;
      repeat (CRLF ? 3 : 2) step();
      inport_accept_i = 1'b0;
      #1;
      chk("cr_tx",     32'(tx_count_o), CRLF ? 3 : 2);
      chk("cr_rx",     32'(rx_count_o), 2);
      chk("cr_ivalid", 32'(inport_valid_o), 0);

      // 6b: reset while an LF is pending
      do_reset();
      exp_q.push_back(8'h0D);
      outport_valid_i = 1'b1;
      outport_data_i  = 8'h0D;
      step();
      outport_data_i  = 8'h41;
      step();
      outport_valid_i = 1'b0;
      inport_accept_i = 1'b1;
      step();
      do_reset();
      #1;
      chk("lfrst_ivalid", 32'(inport_valid_o), 0);
      chk("lfrst_idata",  32'(inport_data_o), 0);
      chk("lfrst_level",  32'(level_o), 0);
      chk("lfrst_tx",     32'(tx_count_o), 0);
      exp_q.push_back(8'h42);
      outport_valid_i = 1'b1;
      outport_data_i  = 8'h62;
      step();
      outport_valid_i = 1'b0;
      inport_accept_i = 1'b1;
      repeat (2) step();
      inport_accept_i = 1'b0;
      #1;
      chk("lfrst_after_tx", 32'(tx_count_o), 1);
      chk("sb_empty", 32'(exp_q.size()), 0);

      $display("[TB] %0d tests run, %0d failed", tests_run, fail_cnt);
      $finish;
   end

endmodule
